crashpu_imem: RTL and testbench

Instruction memory and program loader serving the fetch port of the crashpu core. The core drives `address` and samples `instruction`; this block answers with the stored word one clock later. A byte-stream loader fills the memory at run time and holds the core off while loading. The loader checks each image with an XOR checksum.

---
 rtl/crashpu_imem.sv | 197 +++++++++++++++++++
 tb/tb_crashpu_imem.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/crashpu_imem.sv
// crashpu_imem - instruction memory and byte-stream program loader.
//
// Serves the crashpu fetch port: the word at `address` appears on
// `instruction` one clock later. A loader accepts an image of the form
//   N, {b0,b1,b2} x N, trailer
// where the trailer is the XOR of every preceding byte. The core is held
// off (cpu_hold) for the whole load, and fetch returns NOP_WORD meanwhile.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   address           fetch address from the core
//   instruction       registered fetched word
//   ld_start          one-cycle pulse starting an image load (IDLE only)
//   ld_valid/ld_data  load byte stream; transfer when ld_valid & ld_ready
//   ld_ready          loader accepts a byte this cycle
//   cpu_hold          high while a load is in progress
//   loaded / ld_err   result of the last image checksum
module crashpu_imem #(
  parameter int unsigned           CODE_WIDTH = 18,
  parameter int unsigned           CODE_DEPTH = 8,
  parameter logic [CODE_WIDTH-1:0] NOP_WORD   = {CODE_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CODE_DEPTH-1:0] address,
  output logic [CODE_WIDTH-1:0] instruction,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  output logic                  ld_ready,
  output logic                  cpu_hold,
  output logic                  loaded,
  output logic                  ld_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_B0   = 3'd2;
  localparam logic [2:0] ST_B1   = 3'd3;
  localparam logic [2:0] ST_B2   = 3'd4;
  localparam logic [2:0] ST_CHK  = 3'd5;

  logic [CODE_WIDTH-1:0] mem_q [2**CODE_DEPTH];

  logic [2:0]            state_q, state_d;
  logic [CODE_DEPTH-1:0] wptr_q, wptr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            xor_q, xor_d;
  logic [7:0]            b0_q, b0_d;
  logic [7:0]            b1_q, b1_d;
  logic                  loaded_q, loaded_d;
  logic                  ld_err_q, ld_err_d;
  logic                  ld_ready_q, ld_ready_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic [CODE_WIDTH-1:0] instruction_q, instruction_d;

  logic                  xfer_s;
  logic                  we_s;
  logic [CODE_WIDTH-1:0] word_s;

  assign xfer_s = ld_valid & ld_ready_q;
  // Unused high bits of byte2 are dropped here.
  assign word_s = {ld_data[CODE_WIDTH-17:0], b1_q, b0_q};

  // Loader FSM next-state, datapath and status update.
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    loaded_d = loaded_q;
    ld_err_d = ld_err_q;
    we_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          state_d  = ST_HDR;
          wptr_d   = {CODE_DEPTH{1'b0}};
          xor_d    = 8'h00;
          loaded_d = 1'b0;
          ld_err_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
          cnt_d   = ld_data;
          xor_d   = ld_data;
          state_d = (ld_data != 8'd0) ? ST_B0 : ST_CHK;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_B0: begin
        if (xfer_s) begin
          b0_d    = ld_data;
          xor_d   = xor_q ^ ld_data;
          state_d = ST_B1;
        end else begin
          state_d = ST_B0;
        end
      end
      ST_B1: begin
        if (xfer_s) begin
          b1_d    = ld_data;
          xor_d   = xor_q ^ ld_data;
          state_d = ST_B2;
        end else begin
          state_d = ST_B1;
        end
      end
      ST_B2: begin
        if (xfer_s) begin
          we_s    = 1'b1;
          xor_d   = xor_q ^ ld_data;
          // Pointer wraps naturally; oversize images overwrite earlier words.
          wptr_d  = wptr_q + {{(CODE_DEPTH-1){1'b0}}, 1'b1};
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? ST_CHK : ST_B0;
        end else begin
          state_d = ST_B2;
        end
      end
      ST_CHK: begin
        if (xfer_s) begin
          loaded_d = (ld_data == xor_q);
          ld_err_d = (ld_data != xor_q);
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_CHK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Handshake outputs are registered from the next state, so they rise the
    // cycle after ld_start and fall on the edge that accepts the trailer.
    ld_ready_d = (state_d != ST_IDLE);
    cpu_hold_d = (state_d != ST_IDLE);
  end

  // Fetch path: memory word in IDLE, NOP while loading.
  always_comb begin
    if (state_q == ST_IDLE) begin
      instruction_d = mem_q[address];
    end else begin
      instruction_d = NOP_WORD;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wptr_q        <= {CODE_DEPTH{1'b0}};
      cnt_q         <= 8'd0;
      xor_q         <= 8'd0;
      b0_q          <= 8'd0;
      b1_q          <= 8'd0;
      loaded_q      <= 1'b0;
      ld_err_q      <= 1'b0;
      ld_ready_q    <= 1'b0;
      cpu_hold_q    <= 1'b0;
      instruction_q <= NOP_WORD;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      cnt_q         <= cnt_d;
      xor_q         <= xor_d;
      b0_q          <= b0_d;
      b1_q          <= b1_d;
      loaded_q      <= loaded_d;
      ld_err_q      <= ld_err_d;
      ld_ready_q    <= ld_ready_d;
      cpu_hold_q    <= cpu_hold_d;
      instruction_q <= instruction_d;
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[wptr_q] <= word_s;
    end
  end

  assign instruction = instruction_q;
  assign ld_ready    = ld_ready_q;
  assign cpu_hold    = cpu_hold_q;
  assign loaded      = loaded_q;
  assign ld_err      = ld_err_q;

endmodule

// File: tb/tb_crashpu_imem.sv
// tb_crashpu_imem - scoreboard bench for crashpu_imem.
// Stimulus pushes expected {instruction, ld_ready, cpu_hold, loaded, ld_err}
// records tagged with the cycle they become due; a monitor compares them on
// the falling edge of that cycle.
module tb_crashpu_imem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  address;
  logic [17:0] instruction;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        cpu_hold;
  logic        loaded;
  logic        ld_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    bit          chk_i;
    logic [17:0] instr;
    logic [3:0]  flg;   // {ld_ready, cpu_hold, loaded, ld_err}
    string       name;
  } exp_t;

  exp_t sb[$];

  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_LOAD = 4'b1100;
  localparam logic [3:0] F_OK   = 4'b0010;
  localparam logic [3:0] F_BAD  = 4'b0001;

  crashpu_imem #(.CODE_WIDTH(18), .CODE_DEPTH(8), .NOP_WORD(18'h00000)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .instruction(instruction),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .cpu_hold(cpu_hold), .loaded(loaded), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every record whose due cycle has arrived.
  initial begin
    int i;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].due <= cyc) begin
          act = {ld_ready, cpu_hold, loaded, ld_err};
          checks++;
          if ((act !== sb[i].flg) || (sb[i].chk_i && (instruction !== sb[i].instr))) begin
            failures++;
            $display("FAIL %s: got instruction=%05h flags(rdy,hold,ld,err)=%b, expected instruction=%05h%s flags=%b",
                     sb[i].name, instruction, act, sb[i].instr,
                     sb[i].chk_i ? "" : "(unchecked)", sb[i].flg);
          end
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input bit ci, input logic [17:0] ins,
                          input logic [3:0] f, input string nm);
    exp_t e;
    e.due   = cyc + d;
    e.chk_i = ci;
    e.instr = ins;
    e.flg   = f;
    e.name  = nm;
    sb.push_back(e);
  endtask

  // Present one byte and hold it until the edge that transfers it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    ld_valid = 1'b1;
    ld_data  = b;
    n = 0;
    while (ld_ready !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    if (ld_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ld_ready_timeout: got ld_ready=%b, expected 1", ld_ready);
    end
    step();
    ld_valid = 1'b0;
  endtask

  task automatic start_load(input string nm);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    push_exp(0, 1'b0, 18'h00000, F_LOAD, nm);
  endtask

  task automatic fetch(input logic [7:0] a, input logic [17:0] ins,
                       input logic [3:0] f, input string nm);
    address = a;
    push_exp(1, 1'b1, ins, f, nm);
    step();
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    ld_start = 1'b1;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
    address  = 8'h00;

    // Reset held with clock running and ld_start high.
    for (int k = 0; k < 3; k++) begin
      step();
      push_exp(0, 1'b1, 18'h00000, F_IDLE, "reset_hold");
    end
    reset_n  = 1'b1;
    ld_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      push_exp(0, 1'b0, 18'h00000, F_IDLE, "post_reset_idle");
    end
    // ld_valid alone in IDLE does nothing.
    ld_valid = 1'b1;
    ld_data  = 8'h5A;
    for (int k = 0; k < 2; k++) begin
      step();
      push_exp(0, 1'b0, 18'h00000, F_IDLE, "idle_valid_ignored");
    end
    ld_valid = 1'b0;
    step();

    // Good load: 02 | 42 0A 00 | FF FF 03 | 49
    start_load("good_hdr_entry");
    send_byte(8'h02);
    send_byte(8'h42);
    send_byte(8'h0A);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hFF);
    push_exp(0, 1'b1, 18'h00000, F_LOAD, "good_mid_nop");
    send_byte(8'h03);
    send_byte(8'h49);
    push_exp(0, 1'b1, 18'h00000, F_OK, "good_trailer");
    fetch(8'h00, 18'h00A42, F_OK, "good_fetch0");
    fetch(8'h01, 18'h3FFFF, F_OK, "good_fetch1");
    fetch(8'h00, 18'h00A42, F_OK, "good_fetch0_again");

    // Bad checksum: 02 | 34 12 01 | 78 56 02 | 08 (correct trailer 09)
    start_load("bad_hdr_clears_loaded");
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h01);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h02);
    send_byte(8'h08);
    push_exp(0, 1'b1, 18'h00000, F_BAD, "bad_trailer");
    fetch(8'h00, 18'h11234, F_BAD, "bad_fetch0_written");
    fetch(8'h01, 18'h25678, F_BAD, "bad_fetch1_written");

    // Zero-length image: 00 | 00
    start_load("zero_hdr_clears_err");
    send_byte(8'h00);
    push_exp(0, 1'b1, 18'h00000, F_LOAD, "zero_after_hdr");
    send_byte(8'h00);
    push_exp(0, 1'b1, 18'h00000, F_OK, "zero_trailer");
    fetch(8'h00, 18'h11234, F_OK, "zero_mem0_kept");
    fetch(8'h01, 18'h25678, F_OK, "zero_mem1_kept");

    // Reset after word 0 of a 2-word image.
    start_load("mid_hdr_entry");
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'h03);
    reset_n = 1'b0;
    #1;
    push_exp(0, 1'b1, 18'h00000, F_IDLE, "mid_reset_outputs");
    step();
    step();
    reset_n = 1'b1;
    push_exp(0, 1'b1, 18'h00000, F_IDLE, "mid_reset_release");
    fetch(8'h00, 18'h3BBAA, F_IDLE, "mid_new_word0");
    fetch(8'h01, 18'h25678, F_IDLE, "mid_old_word1");

    // Flow control: ld_valid toggles every cycle during the good image.
    start_load("flow_hdr_entry");
    begin
      logic [7:0] img [8];
      img = '{8'h02, 8'h42, 8'h0A, 8'h00, 8'hFF, 8'hFF, 8'h03, 8'h49};
      for (int k = 0; k < 7; k++) begin
        send_byte(img[k]);
        step();
        push_exp(0, 1'b1, 18'h00000, F_LOAD, "flow_gap_nop");
      end
      send_byte(img[7]);
    end
    push_exp(0, 1'b1, 18'h00000, F_OK, "flow_trailer");
    fetch(8'h00, 18'h00A42, F_OK, "flow_fetch0");
    fetch(8'h01, 18'h3FFFF, F_OK, "flow_fetch1");

    // Drain the scoreboard with a bound.
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending records, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
